// File: rtl/pc_seq_pkg.sv
// Shared encodings and defaults for the program sequencer.
package pc_seq_pkg;

  // Flow ops issued by the decoder; code 7 is unused and behaves as NEXT.
  typedef enum logic [2:0] {
    PC_OP_NEXT   = 3'd0,
    PC_OP_JUMP   = 3'd1,
    PC_OP_BRANCH = 3'd2,
    PC_OP_CALL   = 3'd3,
    PC_OP_RET    = 3'd4,
    PC_OP_RETI   = 3'd5,
    PC_OP_HOLD   = 3'd6
  } pc_op_e;

  typedef enum logic {
    PC_ST_RUN  = 1'b0,
    PC_ST_HALT = 1'b1
  } pc_state_e;

  localparam int unsigned PC_DEF_RESET_VECTOR  = 0;
  localparam int unsigned PC_DEF_VECTOR_BASE   = 32'hF0;
  localparam int unsigned PC_DEF_VECTOR_STRIDE = 2;

endpackage

// File: rtl/pc_call_stack.sv
// Hardware return stack: LIFO with occupancy count 0..DEPTH.
// Push while full and pop while empty are ignored; the owner flags faults.
module pc_call_stack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]          sp;
  logic [PTR_W-1:0]        top_idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign full     = (sp == (PTR_W+1)'(DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = PTR_W'(sp - (PTR_W+1)'(1));
  assign data_out = mem[top_idx];

  // Stack pointer: increments on accepted push, decrements on accepted pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (PTR_W+1)'(1);
    end
  end

  // Entry storage, written at the current pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[sp[PTR_W-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: registered PC, flow ops, return stack, vectored
// masked-priority interrupts and sticky stack-fault halt.
// Optional build macro PC_IRQ_NEST_EN enables priority-based interrupt nesting.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned IRQ_NUM       = 8,
  parameter int unsigned STACK_DEPTH   = 4,
  parameter int unsigned RESET_VECTOR  = PC_DEF_RESET_VECTOR,
  parameter int unsigned VECTOR_BASE   = PC_DEF_VECTOR_BASE,
  parameter int unsigned VECTOR_STRIDE = PC_DEF_VECTOR_STRIDE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_en,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  cond,
  input  logic [IRQ_NUM-1:0]    irq_req,
  input  logic                  mask_we,
  input  logic [IRQ_NUM-1:0]    mask_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [IRQ_NUM-1:0]    irq_ack,
  output logic                  int_active,
  output logic                  stack_ovf,
  output logic                  stack_unf,
  output logic                  halted
);

  localparam int unsigned IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
`ifdef PC_IRQ_NEST_EN
  localparam int unsigned LVL_W   = $clog2(IRQ_NUM + 1);
  localparam int unsigned ENTRY_W = ADDR_WIDTH + LVL_W + 1;
`else
  localparam int unsigned ENTRY_W = ADDR_WIDTH;
`endif

  pc_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, pc_inc, op_pc, push_addr, vec_addr;
  logic [IRQ_NUM-1:0]    irq_mask, pending, ack_nxt;
  logic                  int_nxt, ovf_nxt, unf_nxt;
  logic                  op_push, op_pop, op_reti, irq_op;
  logic                  run_step, irq_allow, take_irq, push_req, found;
  logic [IDX_W-1:0]      irq_idx;
  logic                  st_push, st_pop, st_full, st_empty;
  logic [ENTRY_W-1:0]    st_din, st_dout;
`ifdef PC_IRQ_NEST_EN
  logic [LVL_W-1:0]      cur_level, lvl_nxt;
`endif

  assign pc_inc   = pc + ADDR_WIDTH'(1);
  assign pending  = irq_req & irq_mask;
  assign run_step = (state == PC_ST_RUN) && step_en;
  assign vec_addr = ADDR_WIDTH'(VECTOR_BASE + 32'(irq_idx) * VECTOR_STRIDE);
  assign rom_addr = pc;
  assign halted   = (state == PC_ST_HALT);

`ifdef PC_IRQ_NEST_EN
  assign irq_allow = !int_active || (LVL_W'(irq_idx) < cur_level);
`else
  assign irq_allow = !int_active;
`endif
  assign take_irq  = run_step && irq_op && found && irq_allow;
  assign push_req  = op_push || take_irq;
  // An interrupt stacks where the interrupted op would have gone; a CALL stacks pc+1.
  assign push_addr = take_irq ? op_pc : pc_inc;

`ifdef PC_IRQ_NEST_EN
  assign st_din = {int_active, cur_level, push_addr};
`else
  assign st_din = push_addr;
`endif

  // Lowest-index pending request wins.
  always_comb begin
    irq_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      if (pending[i] && !found) begin
        irq_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  // Decode the flow op into its sequential target and stack action.
  always_comb begin
    op_pc   = pc_inc;
    op_push = 1'b0;
    op_pop  = 1'b0;
    op_reti = 1'b0;
    irq_op  = 1'b1;
    case (op)
      PC_OP_JUMP:   op_pc = target;
      PC_OP_BRANCH: op_pc = cond ? target : pc_inc;
      PC_OP_CALL: begin
        op_pc   = target;
        op_push = 1'b1;
        irq_op  = 1'b0;
      end
      PC_OP_RET: begin
        op_pop = 1'b1;
        irq_op = 1'b0;
      end
      PC_OP_RETI: begin
        op_pop  = 1'b1;
        op_reti = 1'b1;
        irq_op  = 1'b0;
      end
      PC_OP_HOLD:   op_pc = pc;
      default:      op_pc = pc_inc;
    endcase
  end

  // Next-state: stack fault checks take precedence and freeze the PC.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    int_nxt   = int_active;
    ovf_nxt   = stack_ovf;
    unf_nxt   = stack_unf;
    ack_nxt   = '0;
    st_push   = 1'b0;
    st_pop    = 1'b0;
`ifdef PC_IRQ_NEST_EN
    lvl_nxt   = cur_level;
`endif
    if (run_step) begin
      if (push_req && st_full) begin
        ovf_nxt   = 1'b1;
        state_nxt = PC_ST_HALT;
      end else if (op_pop && st_empty) begin
        unf_nxt   = 1'b1;
        state_nxt = PC_ST_HALT;
      end else begin
        st_push = push_req;
        st_pop  = op_pop;
        if (take_irq) begin
          pc_nxt           = vec_addr;
          int_nxt          = 1'b1;
          ack_nxt[irq_idx] = 1'b1;
`ifdef PC_IRQ_NEST_EN
          lvl_nxt          = LVL_W'(irq_idx);
`endif
        end else if (op_pop) begin
          pc_nxt = st_dout[ADDR_WIDTH-1:0];
        end else begin
          pc_nxt = op_pc;
        end
        if (op_reti) begin
`ifdef PC_IRQ_NEST_EN
          int_nxt = st_dout[ENTRY_W-1];
          lvl_nxt = st_dout[ADDR_WIDTH +: LVL_W];
`else
          int_nxt = 1'b0;
`endif
        end
      end
    end
  end

  // Architectural registers; reset wins over everything, mask writes ignore stalls and HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PC_ST_RUN;
      pc         <= ADDR_WIDTH'(RESET_VECTOR);
      irq_mask   <= '0;
      int_active <= 1'b0;
      irq_ack    <= '0;
      stack_ovf  <= 1'b0;
      stack_unf  <= 1'b0;
`ifdef PC_IRQ_NEST_EN
      cur_level  <= LVL_W'(IRQ_NUM);
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      int_active <= int_nxt;
      irq_ack    <= ack_nxt;
      stack_ovf  <= ovf_nxt;
      stack_unf  <= unf_nxt;
`ifdef PC_IRQ_NEST_EN
      cur_level  <= lvl_nxt;
`endif
      if (mask_we) begin
        irq_mask <= mask_data;
      end
    end
  end

  pc_call_stack #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (st_push),
    .pop      (st_pop),
    .data_in  (st_din),
    .data_out (st_dout),
    .full     (st_full),
    .empty    (st_empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default build, PC_IRQ_NEST_EN undefined).
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       step_en;
  logic [2:0] op;
  logic [7:0] target;
  logic       cond;
  logic [7:0] irq_req;
  logic       mask_we;
  logic [7:0] mask_data;
  logic [7:0] rom_addr;
  logic [7:0] irq_ack;
  logic       int_active;
  logic       stack_ovf;
  logic       stack_unf;
  logic       halted;

  pc_sequencer #(
    .ADDR_WIDTH    (8),
    .IRQ_NUM       (8),
    .STACK_DEPTH   (4),
    .RESET_VECTOR  (0),
    .VECTOR_BASE   (32'hF0),
    .VECTOR_STRIDE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_en    (step_en),
    .op         (op),
    .target     (target),
    .cond       (cond),
    .irq_req    (irq_req),
    .mask_we    (mask_we),
    .mask_data  (mask_data),
    .rom_addr   (rom_addr),
    .irq_ack    (irq_ack),
    .int_active (int_active),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ack;
    logic       ia;
    logic       ovf;
    logic       unf;
    logic       halt;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic [7:0] m_mask;
  logic       m_int, m_ovf, m_unf, m_halt;
  logic [7:0] m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic en, input logic [2:0] o, input logic [7:0] t,
                       input logic c, input logic [7:0] irq, input logic mwe, input logic [7:0] md);
    logic [7:0] nxt, inc, push_v, pend;
    logic       push, pop, reti, take;
    int         idx;
    if (r) begin
      m_pc = 8'h00; m_stack.delete(); m_mask = 8'h00;
      m_int = 0; m_ovf = 0; m_unf = 0; m_halt = 0; m_ack = 8'h00;
    end else begin
      pend  = irq & m_mask;
      m_ack = 8'h00;
      if (mwe) m_mask = md;
      if (!m_halt && en) begin
        inc = m_pc + 8'd1; nxt = inc; push = 0; pop = 0; reti = 0; push_v = inc;
        case (o)
          3'd1: nxt = t;
          3'd2: nxt = c ? t : inc;
          3'd3: begin push = 1; push_v = inc; nxt = t; end
          3'd4: pop = 1;
          3'd5: begin pop = 1; reti = 1; end
          3'd6: nxt = m_pc;
          default: ;
        endcase
        take = !(o inside {3'd3, 3'd4, 3'd5}) && !m_int && (pend != 0);
        idx = 0;
        if (take) begin
          for (int i = 7; i >= 0; i--) if (pend[i]) idx = i;
          push = 1; push_v = nxt;
          nxt = 8'(8'hF0 + idx * 2);
        end
        if (push && m_stack.size() == 4) begin
          m_ovf = 1; m_halt = 1;
        end else if (pop && m_stack.size() == 0) begin
          m_unf = 1; m_halt = 1;
        end else begin
          if (push) m_stack.push_back(push_v);
          if (pop) nxt = m_stack.pop_back();
          m_pc = nxt;
          if (take) begin m_int = 1; m_ack = 8'(1 << idx); end
          if (reti) m_int = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic [2:0] o, input logic [7:0] t,
                       input logic c, input logic [7:0] irq, input logic mwe, input logic [7:0] md);
    exp_t e, g;
    rst = r; step_en = en; op = o; target = t; cond = c;
    irq_req = irq; mask_we = mwe; mask_data = md;
    model(r, en, o, t, c, irq, mwe, md);
    e.pc = m_pc; e.ack = m_ack; e.ia = m_int; e.ovf = m_ovf; e.unf = m_unf; e.halt = m_halt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      check("rom_addr",   rom_addr,   g.pc);
      check("irq_ack",    irq_ack,    g.ack);
      check("int_active", int_active, g.ia);
      check("stack_ovf",  stack_ovf,  g.ovf);
      check("stack_unf",  stack_unf,  g.unf);
      check("halted",     halted,     g.halt);
    end
  endtask

  task automatic do_rst();
    cycle(1, 0, 3'd0, 8'h00, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic step(input logic [2:0] o, input logic [7:0] t, input logic c, input logic [7:0] irq);
    cycle(0, 1, o, t, c, irq, 0, 8'h00);
  endtask

  initial begin
    rst = 1; step_en = 0; op = 0; target = 0; cond = 0;
    irq_req = 0; mask_we = 0; mask_data = 0;

    // Reset and sequential fetch
    do_rst();
    check("reset_pc", rom_addr, 8'h00);
    repeat (3) step(3'd0, 8'h00, 0, 8'h00);
    check("next3_pc", rom_addr, 8'h03);

    // Wrap at all-ones
    step(3'd1, 8'hFF, 0, 8'h00);
    step(3'd0, 8'h00, 0, 8'h00);
    check("wrap_pc", rom_addr, 8'h00);

    // Call/return and branch
    step(3'd1, 8'h10, 0, 8'h00);
    step(3'd3, 8'h40, 0, 8'h00);
    check("call_pc", rom_addr, 8'h40);
    step(3'd4, 8'h00, 0, 8'h00);
    check("ret_pc", rom_addr, 8'h11);
    step(3'd2, 8'h80, 0, 8'h00);
    check("br0_pc", rom_addr, 8'h12);
    step(3'd2, 8'h80, 1, 8'h00);
    check("br1_pc", rom_addr, 8'h80);
    step(3'd7, 8'h00, 0, 8'h00);
    step(3'd6, 8'h00, 0, 8'h00);

    // Masked priority interrupt entry and RETI
    cycle(0, 1, 3'd1, 8'h20, 0, 8'h00, 1, 8'h0C);
    step(3'd0, 8'h00, 0, 8'h0E);
    check("irq_vec", rom_addr, 8'hF4);
    check("irq_ack1", irq_ack, 8'h04);
    step(3'd0, 8'h00, 0, 8'h0E);
    check("irq_ack_pulse", irq_ack, 8'h00);
    step(3'd5, 8'h00, 0, 8'h0E);
    check("reti_pc", rom_addr, 8'h21);
    check("reti_ia", int_active, 1'b0);

    // Deferral behind CALL, then entry stacks the call target path
    step(3'd1, 8'h30, 0, 8'h00);
    step(3'd3, 8'h50, 0, 8'h04);
    check("defer_ack", irq_ack, 8'h00);
    step(3'd0, 8'h00, 0, 8'h04);
    step(3'd5, 8'h00, 0, 8'h00);
    check("defer_ret", rom_addr, 8'h51);
    step(3'd4, 8'h00, 0, 8'h00);

    // Stall with pending interrupt, then reset while handler active
    repeat (5) cycle(0, 0, 3'd1, 8'hAA, 1, 8'h04, 0, 8'h00);
    check("stall_pc", rom_addr, 8'h31);
    step(3'd0, 8'h00, 0, 8'h04);
    check("pre_rst_ia", int_active, 1'b1);
    do_rst();

    // Overflow after five nested calls
    repeat (5) step(3'd3, 8'h40, 0, 8'h00);
    check("ovf_flag", stack_ovf, 1'b1);
    step(3'd0, 8'h00, 0, 8'hFF);
    step(3'd1, 8'h77, 0, 8'h00);
    do_rst();

    // Underflow from reset; HALT ignores steps and interrupts
    cycle(0, 1, 3'd0, 8'h00, 0, 8'h00, 1, 8'hFF);
    step(3'd4, 8'h00, 0, 8'h00);
    check("unf_flag", stack_unf, 1'b1);
    step(3'd0, 8'h00, 0, 8'hFF);
    step(3'd5, 8'h00, 0, 8'h00);
    do_rst();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 60) == 0);
      cycle(r, ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
            ($urandom_range(0, 9) == 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program sequencer for the microcontroller core.
- Holds the registered program counter that drives the ROM address, and executes the flow ops issued by the decoder: next, jump, branch, call, return and return-from-interrupt.
- Adds a hardware call/return stack, a multi-source masked priority interrupt controller with vectoring, and sticky stack-fault detection, which the previous PC had none of.
- Sits between the decoder (op/target/cond) and the ROM (rom_addr).

Parameters:
- ADDR_WIDTH, 8, width of PC, ROM address, target, vectors.
- IRQ_NUM, 8, number of interrupt sources (1..16).
- STACK_DEPTH, 4, return-stack entries (power of two, >=2).
- RESET_VECTOR, 0, PC value after reset.
- VECTOR_BASE, 8'hF0, address of vector for source 0.
- VECTOR_STRIDE, 2, address step between consecutive source vectors.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- step_en  in  1  1 = advance one instruction this cycle; 0 = stall, hold all state.
- op  in  3  flow op from decoder (encodings in package).
- target  in  ADDR_WIDTH  jump/branch/call destination.
- cond  in  1  branch condition.
- irq_req  in  IRQ_NUM  level interrupt requests.
- mask_we  in  1  write irq_mask.
- mask_data  in  IRQ_NUM  new mask, 1 = enabled.
- rom_addr  out  ADDR_WIDTH  current PC.
- irq_ack  out  IRQ_NUM  one-hot, one-cycle pulse on interrupt entry.
- int_active  out  1  handler in progress.
- stack_ovf  out  1  sticky overflow.
- stack_unf  out  1  sticky underflow.
- halted  out  1  fault state.

Behaviour:
- Reset values: rom_addr = RESET_VECTOR; sp = 0; irq_mask = 0; int_active = 0; irq_ack = 0; stack_ovf = 0; stack_unf = 0; halted = 0; state = RUN.
- States: RUN, HALT. Only reset leaves HALT.
- mask_we updates irq_mask next edge regardless of step_en or state.
- In RUN with step_en = 1, next_pc is computed from op. PC arithmetic is modulo 2^ADDR_WIDTH, so the address after all-ones is 0.
  - NEXT (0): pc+1.
  - JUMP (1): target.
  - BRANCH (2): cond ? target : pc+1.
  - CALL (3): push pc+1, then target.
  - RET (4): pop.
  - RETI (5): pop and clear int_active.
  - HOLD (6): pc.
  - Code 7 is treated as NEXT.
- step_en = 0: pc, stack and int_active unchanged; irq_ack = 0.
- Interrupt pending = irq_req & irq_mask. The winner is the lowest set index.
- Interrupts are taken only when all of these hold: state RUN, step_en = 1, int_active = 0, pending != 0, and op is one of NEXT/JUMP/BRANCH/HOLD.
- Interrupt entry:
  - push next_pc of the current op;
  - pc = VECTOR_BASE + idx*VECTOR_STRIDE (truncated to ADDR_WIDTH);
  - int_active = 1;
  - irq_ack[idx] = 1 for exactly that cycle.
- Interrupt deferral: if op is CALL/RET/RETI, the interrupt waits one step.
- Latency: rom_addr reflects the op one edge after step_en.
- Stack is LIFO with sp counting 0..STACK_DEPTH.
- Push with sp == STACK_DEPTH: no write; stack_ovf = 1, halted = 1, state HALT, pc frozen.
- Pop with sp == 0: stack_unf = 1, halted = 1, state HALT, pc frozen.
- In HALT, step_en, op and irq_req are ignored; irq_ack = 0; mask writes are still accepted.
- Reset asserted mid-handler or mid-stall restores all reset values on that edge.

Optional Feature:
- PC_IRQ_NEST_EN defined:
  - each stack entry also stores the active priority level;
  - an interrupt preempts while int_active = 1 if its index is strictly lower than the current level;
  - RETI restores the popped level, and clears int_active only when the popped entry was pushed from non-interrupt context.
- PC_IRQ_NEST_EN undefined: no nesting, as specified above.

Decomposition:
- Package pc_seq_pkg holds:
  - op encodings PC_OP_NEXT..PC_OP_HOLD;
  - state encoding PC_ST_RUN/PC_ST_HALT;
  - default vector constants.
- One sub-module, pc_call_stack: parametrised LIFO with push/pop/data_in/data_out/full/empty, synchronous active-high reset. pc_sequencer owns fault detection.

Test Plan:
- Reset, then 3 NEXT steps with ADDR_WIDTH=8 -> rom_addr 0,1,2,3. Start at pc=8'hFF, NEXT -> 8'h00.
- At pc=8'h10: CALL target 8'h40 -> pc 8'h40, sp 1. RET -> pc 8'h11, sp 0. BRANCH cond=0 -> pc+1; cond=1 -> target.
- mask=8'h0C, irq_req=8'h0E, NEXT at pc 8'h20 -> irq_ack=8'h04 for one cycle, pc=8'hF4, int_active=1. RETI -> pc 8'h21, int_active=0.
- irq pending while op=CALL -> no entry that step. Entry occurs on the following NEXT, with the stacked address taken from the call target path.
- STACK_DEPTH=4: 5 nested CALLs -> stack_ovf=1, halted=1, rom_addr frozen. RET from reset -> stack_unf=1. rst clears both.
- step_en=0 held 5 cycles with irq pending -> no change, irq_ack=0. Assert rst while int_active=1 -> all outputs at reset values next edge.
